// File: rtl/tracker_pkg.sv
// Shared types for the NoC packet tracker record path.
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOG_WR   = 2'd1,
    PASS_HDR = 2'd2,
    BODY     = 2'd3
  } tracker_record_state_e;

endpackage

// File: rtl/tracker_record_ctrl.sv
// Record-path control FSM: filter decision, one log write per recorded packet, then header/body pass-through.
// Optional TRACKER_RECORD_DROP_EN: drop the log record instead of stalling the NoC when the log path is busy.
module tracker_record_ctrl
  import tracker_pkg::*;
#(
  parameter int DROP_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  noc_wr_tracker_in_val,
  output logic                  wr_tracker_noc_in_rdy,
  output logic                  wr_tracker_noc_out_val,
  input  logic                  noc_wr_tracker_out_rdy,
  input  logic                  datap_ctrl_filter_val,
  input  logic                  datap_ctrl_filter_record,
  output logic                  ctrl_datap_filter_rdy,
  input  logic                  datap_ctrl_last_flit,
  output logic                  ctrl_datap_store_hdr,
  output logic                  ctrl_datap_incr_flits,
  output logic                  log_wr_req_val,
  input  logic                  log_wr_req_rdy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  tracker_record_state_e state, state_nxt;
  logic xfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A flit moves only when both sides agree; the flit itself never leaves the datapath registers.
  assign xfer = noc_wr_tracker_in_val & noc_wr_tracker_out_rdy;

  always_comb begin
    state_nxt              = state;
    wr_tracker_noc_in_rdy  = 1'b0;
    wr_tracker_noc_out_val = 1'b0;
    ctrl_datap_filter_rdy  = 1'b0;
    ctrl_datap_store_hdr   = 1'b0;
    ctrl_datap_incr_flits  = 1'b0;
    log_wr_req_val         = 1'b0;
    case (state)
      IDLE: begin
        if (noc_wr_tracker_in_val && datap_ctrl_filter_val) begin
          ctrl_datap_filter_rdy = 1'b1;
          state_nxt = datap_ctrl_filter_record ? LOG_WR : PASS_HDR;
        end
      end
      LOG_WR: begin
        log_wr_req_val = 1'b1;
`ifdef TRACKER_RECORD_DROP_EN
        // One shot at the log: either accepted or dropped, the header moves on next cycle.
        state_nxt = PASS_HDR;
`else
        if (log_wr_req_rdy) state_nxt = PASS_HDR;
`endif
      end
      PASS_HDR: begin
        wr_tracker_noc_out_val = noc_wr_tracker_in_val;
        wr_tracker_noc_in_rdy  = noc_wr_tracker_out_rdy;
        if (xfer) begin
          ctrl_datap_store_hdr = 1'b1;
          state_nxt = datap_ctrl_last_flit ? IDLE : BODY;
        end
      end
      BODY: begin
        wr_tracker_noc_out_val = noc_wr_tracker_in_val;
        wr_tracker_noc_in_rdy  = noc_wr_tracker_out_rdy;
        if (xfer) begin
          ctrl_datap_incr_flits = 1'b1;
          if (datap_ctrl_last_flit) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TRACKER_RECORD_DROP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (state == LOG_WR && !log_wr_req_rdy && drop_cnt != {DROP_CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_tracker_record_ctrl.sv
// Self-checking bench for tracker_record_ctrl: directed scenarios plus a randomized packet stream.
module tb_tracker_record_ctrl;
  import tracker_pkg::*;

  localparam int DROP_CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic in_val, in_rdy, out_val, out_rdy;
  logic filter_val, filter_record, filter_rdy, last_flit;
  logic store_hdr, incr_flits, log_val, log_rdy;
  logic [DROP_CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  tracker_record_ctrl #(.DROP_CNT_W(DROP_CNT_W)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .noc_wr_tracker_in_val    (in_val),
    .wr_tracker_noc_in_rdy    (in_rdy),
    .wr_tracker_noc_out_val   (out_val),
    .noc_wr_tracker_out_rdy   (out_rdy),
    .datap_ctrl_filter_val    (filter_val),
    .datap_ctrl_filter_record (filter_record),
    .ctrl_datap_filter_rdy    (filter_rdy),
    .datap_ctrl_last_flit     (last_flit),
    .ctrl_datap_store_hdr     (store_hdr),
    .ctrl_datap_incr_flits    (incr_flits),
    .log_wr_req_val           (log_val),
    .log_wr_req_rdy           (log_rdy),
    .drop_cnt                 (drop_cnt)
  );

  typedef struct {
    int id;
    bit hdr;
    bit last;
    bit rec;
  } flit_t;

  flit_t src[$];
  int    exp_ids[$];
  int    out_ids[$];
  int    xfer_cyc[$];
  int    sp, cyc, next_id;
  int    n_checks = 0;
  int    n_pass = 0;

  // stimulus shaping
  bit rand_mode;
  int orl_start, orl_len, lrl_len;

  // observations
  int n_log_acc, n_log_val, n_store, n_incr, n_filt, n_viol, n_body_stall;
  bit done;

  task automatic add_pkt(input int len, input bit rec);
    for (int i = 0; i <= len; i++) begin
      flit_t f;
      f.id = next_id;
      f.hdr = (i == 0);
      f.last = (i == len);
      f.rec = rec;
      next_id++;
      src.push_back(f);
      exp_ids.push_back(f.id);
    end
  endtask

  task automatic clear_stream();
    src.delete(); exp_ids.delete(); out_ids.delete(); xfer_cyc.delete();
    sp = 0; cyc = 0;
    n_log_acc = 0; n_log_val = 0; n_store = 0; n_incr = 0; n_filt = 0;
    n_viol = 0; n_body_stall = 0; done = 0;
    rand_mode = 0; orl_start = 0; orl_len = 0; lrl_len = 0;
  endtask

  task automatic drive_inputs();
    if (sp < src.size()) begin
      in_val = 1'b1;
      filter_val = src[sp].hdr;
      filter_record = src[sp].rec;
      last_flit = src[sp].last;
    end else begin
      in_val = 1'b0; filter_val = 1'b0; filter_record = 1'b0; last_flit = 1'b0;
    end
    if (rand_mode) begin
      out_rdy = ($urandom_range(0, 9) < 7);
      log_rdy = ($urandom_range(0, 9) < 6);
    end else begin
      out_rdy = !(cyc >= orl_start && cyc < orl_start + orl_len);
      log_rdy = (cyc >= lrl_len);
    end
  endtask

  // Runs the queued stream; stop_xfers >= 0 halts after that many flits have moved.
  task automatic run(input int max_cyc, input int stop_xfers);
    bit xfer;
    drive_inputs();
    while (sp < src.size() && cyc < max_cyc && (stop_xfers < 0 || out_ids.size() < stop_xfers)) begin
      @(negedge clk);
      xfer = in_val && in_rdy;
      if (store_hdr && incr_flits) n_viol++;
      if ((store_hdr || incr_flits) && !xfer) n_viol++;
      if (in_rdy && !out_rdy) n_viol++;
      if (out_val && !in_val) n_viol++;
      if (xfer && !out_val) n_viol++;
      if (out_val && out_rdy && !in_rdy) n_viol++;
      if (store_hdr && !(xfer && src[sp].hdr)) n_viol++;
      if (incr_flits && !(xfer && !src[sp].hdr)) n_viol++;
      if (log_val) n_log_val++;
      if (log_val && log_rdy) n_log_acc++;
      if (filter_rdy) n_filt++;
      if (store_hdr) n_store++;
      if (incr_flits) n_incr++;
      if (dut.state == BODY && !in_rdy) n_body_stall++;
      if (xfer) begin
        out_ids.push_back(src[sp].id);
        xfer_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (xfer) sp++;
      cyc++;
      drive_inputs();
    end
    done = (sp == src.size());
  endtask

  task automatic check_order(input string name);
    bit ok = (out_ids.size() == exp_ids.size());
    for (int i = 0; i < out_ids.size() && ok; i++) if (out_ids[i] != exp_ids[i]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL %s_order got %0d flits exp %0d in order", name, out_ids.size(), exp_ids.size());
    else n_pass++;
    n_checks++;
    if (n_viol !== 0) $display("FAIL %s_handshake got %0d violations exp 0", name, n_viol);
    else n_pass++;
  endtask

  task automatic check_cycles(input string name, input int exp_c[$]);
    bit ok = (xfer_cyc.size() == exp_c.size());
    for (int i = 0; i < exp_c.size() && ok; i++) if (xfer_cyc[i] != exp_c[i]) ok = 0;
    n_checks++;
    if (!ok) $display("FAIL %s_timing got first xfer cycle %0d count %0d exp first %0d count %0d", name,
                      (xfer_cyc.size() > 0) ? xfer_cyc[0] : -1, xfer_cyc.size(), exp_c[0], exp_c.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_stream();
    drive_inputs();
    @(negedge clk);
    n_checks++;
    if (dut.state !== IDLE) $display("FAIL reset_state got %0d exp %0d", dut.state, IDLE);
    else n_pass++;
    n_checks++;
    if ({in_rdy, out_val, filter_rdy, store_hdr, incr_flits, log_val} !== 6'b0)
      $display("FAIL reset_outputs got %b exp 000000", {in_rdy, out_val, filter_rdy, store_hdr, incr_flits, log_val});
    else n_pass++;
    n_checks++;
    if (drop_cnt !== '0) $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_record_pass();
    clear_stream();
    add_pkt(3, 1);
    run(100, -1);
    check_order("t1");
    check_cycles("t1", '{2, 3, 4, 5});
    n_checks++;
    if (n_log_acc !== 1) $display("FAIL t1_log_req got %0d exp 1", n_log_acc); else n_pass++;
    n_checks++;
    if (n_store !== 1 || n_incr !== 3) $display("FAIL t1_store_incr got %0d/%0d exp 1/3", n_store, n_incr); else n_pass++;
    n_checks++;
    if (n_filt !== 1) $display("FAIL t1_filter_rdy got %0d exp 1", n_filt); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut.state !== IDLE) $display("FAIL t1_end_state got %0d exp %0d", dut.state, IDLE); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len_pass();
    clear_stream();
    add_pkt(0, 0);
    run(100, -1);
    check_order("t2");
    check_cycles("t2", '{1});
    n_checks++;
    if (n_log_val !== 0 || n_filt !== 1 || n_store !== 1 || n_incr !== 0)
      $display("FAIL t2_counts got log %0d filt %0d store %0d incr %0d exp 0 1 1 0", n_log_val, n_filt, n_store, n_incr);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (dut.state !== IDLE) $display("FAIL t2_end_state got %0d exp %0d", dut.state, IDLE); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_body_stall();
    clear_stream();
    add_pkt(2, 0);
    orl_start = 3; orl_len = 5;
    drive_inputs();
    run(100, -1);
    check_order("t3");
    check_cycles("t3", '{1, 2, 8});
    n_checks++;
    if (n_incr !== 2) $display("FAIL t3_incr got %0d exp 2", n_incr); else n_pass++;
    n_checks++;
    if (n_body_stall !== 5) $display("FAIL t3_body_held got %0d exp 5", n_body_stall); else n_pass++;
  endtask

  task automatic test_log_backpressure();
    clear_stream();
    add_pkt(1, 1);
    lrl_len = 10;
    drive_inputs();
    run(100, -1);
    check_order("t4");
`ifdef TRACKER_RECORD_DROP_EN
    check_cycles("t4", '{2, 3});
    n_checks++;
    if (n_log_acc !== 0 || n_log_val !== 1) $display("FAIL t4_log got acc %0d val %0d exp 0 1", n_log_acc, n_log_val);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 1) $display("FAIL t4_drop_cnt got %0d exp 1", drop_cnt); else n_pass++;
`else
    check_cycles("t4", '{11, 12});
    n_checks++;
    if (n_log_acc !== 1 || n_log_val !== 10) $display("FAIL t4_log got acc %0d val %0d exp 1 10", n_log_acc, n_log_val);
    else n_pass++;
    n_checks++;
    if (drop_cnt !== 0) $display("FAIL t4_drop_cnt got %0d exp 0", drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    clear_stream();
    add_pkt(1, 0);
    add_pkt(2, 0);
    run(100, -1);
    check_order("t5");
    check_cycles("t5", '{1, 2, 4, 5, 6});
    n_checks++;
    if (n_filt !== 2 || n_store !== 2 || n_incr !== 3)
      $display("FAIL t5_counts got filt %0d store %0d incr %0d exp 2 2 3", n_filt, n_store, n_incr);
    else n_pass++;
  endtask

  task automatic test_random();
    int n_rec = 0, n_pkt = 25, body = 0;
    logic [DROP_CNT_W-1:0] drop0;
    clear_stream();
    drop0 = drop_cnt;
    for (int p = 0; p < n_pkt; p++) begin
      int len = $urandom_range(0, 5);
      bit rec = $urandom_range(0, 1);
      add_pkt(len, rec);
      n_rec += rec;
      body += len;
    end
    rand_mode = 1;
    drive_inputs();
    run(4000, -1);
    n_checks++;
    if (!done) $display("FAIL rand_timeout got %0d of %0d flits exp all", sp, src.size()); else n_pass++;
    check_order("rand");
    n_checks++;
    if (n_store !== n_pkt || n_incr !== body || n_filt !== n_pkt)
      $display("FAIL rand_counts got store %0d incr %0d filt %0d exp %0d %0d %0d", n_store, n_incr, n_filt, n_pkt, body, n_pkt);
    else n_pass++;
    n_checks++;
`ifdef TRACKER_RECORD_DROP_EN
    if (n_log_acc + int'(drop_cnt - drop0) !== n_rec)
      $display("FAIL rand_log got acc %0d drops %0d exp sum %0d", n_log_acc, drop_cnt - drop0, n_rec);
    else n_pass++;
`else
    if (n_log_acc !== n_rec) $display("FAIL rand_log got %0d exp %0d", n_log_acc, n_rec);
    else n_pass++;
`endif
  endtask

  task automatic test_mid_packet_reset();
    clear_stream();
    add_pkt(4, 0);
    run(100, 2);
    n_checks++;
    if (dut.state !== BODY) $display("FAIL t6_pre_state got %0d exp %0d", dut.state, BODY); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stream();
    drive_inputs();
    @(negedge clk);
    n_checks++;
    if (dut.state !== IDLE) $display("FAIL t6_state got %0d exp %0d", dut.state, IDLE); else n_pass++;
    n_checks++;
    if ({in_rdy, out_val, filter_rdy, store_hdr, incr_flits, log_val} !== 6'b0 || drop_cnt !== '0)
      $display("FAIL t6_outputs got %b drop %0d exp 000000 drop 0",
               {in_rdy, out_val, filter_rdy, store_hdr, incr_flits, log_val}, drop_cnt);
    else n_pass++;
    @(posedge clk); #1;
    clear_stream();
    add_pkt(1, 1);
    run(100, -1);
    check_order("t6_after");
    check_cycles("t6_after", '{2, 3});
    n_checks++;
    if (n_filt !== 1 || n_store !== 1 || n_log_acc !== 1)
      $display("FAIL t6_header got filt %0d store %0d log %0d exp 1 1 1", n_filt, n_store, n_log_acc);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    next_id = 0;
    clear_stream();
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_record_pass();
    test_zero_len_pass();
    test_body_stall();
    test_log_backpressure();
    test_back_to_back();
    test_random();
    test_mid_packet_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
